conv_window_mac: RTL and testbench

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

---
 rtl/conv_pkg.sv | 17 +
 rtl/mul_add16.sv | 79 +++++++
 rtl/conv_window_mac.sv | 99 +++++++++
 tb/tb_conv_window_mac.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and the accumulator state type for the windowed MAC.
package conv_pkg;

  localparam int BYTE_W    = 8;   // one image / filter byte
  localparam int WIN_BYTES = 16;  // 4x4 window
  localparam int PROD_W    = 16;  // byte * byte, full precision
  localparam int WSUM_W    = 20;  // sum of 16 products, full precision
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ROW_W     = 18;  // sum of 4 products, full precision

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/mul_add16.sv
// Stages 1-2 of the window MAC: 16 registered byte products, then four
// registered row sums. The first/last tags and valid bit ride alongside.
module mul_add16
  import conv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [127:0]          window,
  input  logic [127:0]          filter,
  output logic                  s1_valid,
  output logic                  s2_valid,
  output logic                  s2_first,
  output logic                  s2_last,
  output logic [ROWS*ROW_W-1:0] row_sums
);

  logic [PROD_W-1:0] prod_next [WIN_BYTES];
  logic [PROD_W-1:0] prod_reg  [WIN_BYTES];
  logic [ROW_W-1:0]  row_next  [ROWS];
  logic [ROW_W-1:0]  row_reg   [ROWS];
  logic              s1_valid_reg, s1_first_reg, s1_last_reg;
  logic              s2_valid_reg, s2_first_reg, s2_last_reg;

  // Byte k lives at [127-8k -: 8]; k = row*4 + col.
  generate
    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_mul
      assign prod_next[gi] = {8'd0, window[127-BYTE_W*gi -: BYTE_W]} *
                             {8'd0, filter[127-BYTE_W*gi -: BYTE_W]};
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      assign row_next[gi] = ROW_W'(prod_reg[COLS*gi])     + ROW_W'(prod_reg[COLS*gi+1]) +
                            ROW_W'(prod_reg[COLS*gi+2])   + ROW_W'(prod_reg[COLS*gi+3]);
      // Row 0 occupies the top slice of the packed bus.
      assign row_sums[(ROWS-gi)*ROW_W-1 -: ROW_W] = row_reg[gi];
    end
  endgenerate

  // Stage 1: capture products and tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_first_reg <= 1'b0;
      s1_last_reg  <= 1'b0;
      for (int i = 0; i < WIN_BYTES; i++) prod_reg[i] <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      s1_first_reg <= in_valid & in_first;
      s1_last_reg  <= in_valid & in_last;
      for (int i = 0; i < WIN_BYTES; i++) prod_reg[i] <= prod_next[i];
    end
  end

  // Stage 2: capture row sums and forward tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_first_reg <= 1'b0;
      s2_last_reg  <= 1'b0;
      for (int i = 0; i < ROWS; i++) row_reg[i] <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_first_reg <= s1_first_reg;
      s2_last_reg  <= s1_last_reg;
      for (int i = 0; i < ROWS; i++) row_reg[i] <= row_next[i];
    end
  end

  assign s1_valid = s1_valid_reg;
  assign s2_valid = s2_valid_reg;
  assign s2_first = s2_first_reg;
  assign s2_last  = s2_last_reg;

endmodule

// File: rtl/conv_window_mac.sv
// 4x4 window dot product with group accumulation. Stages 1-2 live in
// mul_add16; stage 3 adds the row sums and runs the accumulator FSM.
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [127:0]     window,
  input  logic [127:0]     filter,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic             busy
);

  // One spare bit above the wider of accumulator and pair sum catches overflow.
  localparam int EXT_W = ((ACC_W > WSUM_W) ? ACC_W : WSUM_W) + 1;

  logic                  s1_valid, s2_valid, s2_first, s2_last;
  logic [ROWS*ROW_W-1:0] row_sums;
  logic [WSUM_W-1:0]     pair_sum;
  logic [EXT_W-1:0]      base_ext, total_ext, max_ext;
  logic                  restart, over;
  logic [ACC_W-1:0]      acc_next;
  logic                  sat_next;

  acc_state_t            state_reg;
  logic [ACC_W-1:0]      acc_reg;
  logic                  sat_reg;
  logic                  out_valid_reg;
  logic [ACC_W-1:0]      out_sum_reg;
  logic                  out_sat_reg;

  mul_add16 u_mul_add16 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .window   (window),
    .filter   (filter),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .s2_first (s2_first),
    .s2_last  (s2_last),
    .row_sums (row_sums)
  );

  // Stage-3 arithmetic: pair sum, restart-or-add, saturating clamp.
  always_comb begin
    pair_sum = WSUM_W'(row_sums[4*ROW_W-1 -: ROW_W]) + WSUM_W'(row_sums[3*ROW_W-1 -: ROW_W]) +
               WSUM_W'(row_sums[2*ROW_W-1 -: ROW_W]) + WSUM_W'(row_sums[ROW_W-1 -: ROW_W]);
    // A pair arriving in IDLE opens a group whether or not it carries first.
    restart   = (state_reg == ST_IDLE) || s2_first;
    base_ext  = restart ? '0 : EXT_W'(acc_reg);
    total_ext = base_ext + EXT_W'(pair_sum);
    max_ext   = EXT_W'({ACC_W{1'b1}});
    over      = (total_ext > max_ext);
    acc_next  = over ? {ACC_W{1'b1}} : total_ext[ACC_W-1:0];
    sat_next  = (restart ? 1'b0 : sat_reg) | over;
  end

  // Accumulator FSM with registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      acc_reg       <= '0;
      sat_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_sat_reg   <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      if (s2_valid) begin
        acc_reg <= acc_next;
        sat_reg <= sat_next;
        if (s2_last) begin
          out_valid_reg <= 1'b1;
          out_sum_reg   <= acc_next;
          out_sat_reg   <= sat_next;
          state_reg     <= ST_IDLE;
        end else begin
          state_reg     <= ST_ACC;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_sat   = out_sat_reg;
  assign busy      = s1_valid | s2_valid | (state_reg == ST_ACC);

endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac: expectations are queued as pairs are
// driven and matched against each out_valid pulse, including its edge number.
module tb_conv_window_mac;

  localparam int  ACC_W   = 24;
  localparam longint MAXV = (longint'(1) << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [127:0]     window = '0, filter = '0;
  logic             out_valid, out_sat, busy;
  logic [ACC_W-1:0] out_sum;

  conv_window_mac #(.ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .window    (window),
    .filter    (filter),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    bit     sat;
    int     edge_no;
  } exp_t;

  exp_t   sb_q[$];
  int     total_cnt = 0;
  int     bad_cnt   = 0;
  int     edge_cnt  = 0;
  longint model_acc = 0;
  bit     model_open = 1'b0;
  bit     model_sat  = 1'b0;
  longint hold_sum  = 0;
  bit     hold_sat  = 1'b0;

  logic [127:0] ones, ffs, grp_b_w, grp_b_f;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint pair_sum(input logic [127:0] w, input logic [127:0] f);
    longint s = 0;
    for (int k = 0; k < 16; k++) begin
      int a, b;
      a = int'(w[127-8*k -: 8]);
      b = int'(f[127-8*k -: 8]);
      s += longint'(a * b);
    end
    return s;
  endfunction

  // Drive one pair at the falling edge; the next rising edge captures it and
  // the result is due three rising edges after the drive point.
  task automatic send(input logic [127:0] w, input logic [127:0] f, input bit first,
                      input bit last, input bit use_exp, input longint exp_sum, input bit exp_sat);
    exp_t e;
    longint s;
    @(negedge clk);
    window = w; filter = f; in_first = first; in_last = last; in_valid = 1'b1;
    s = pair_sum(w, f);
    if (!model_open || first) begin
      model_acc = s;
      model_sat = 1'b0;
    end else begin
      model_acc += s;
    end
    if (model_acc > MAXV) begin
      model_acc = MAXV;
      model_sat = 1'b1;
    end
    if (last) begin
      e.sum     = use_exp ? exp_sum : model_acc;
      e.sat     = use_exp ? exp_sat : model_sat;
      e.edge_no = edge_cnt + 3;
      sb_q.push_back(e);
      model_open = 1'b0;
    end else begin
      model_open = 1'b1;
    end
  endtask

  // Idle cycles with garbage tags/data that must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_first = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      window   = {4{$urandom()}};
      filter   = {4{$urandom()}};
    end
  endtask

  // Output monitor: match pulses against the scoreboard, check hold otherwise.
  always @(posedge clk) begin
    #1;
    edge_cnt++;
    if (!rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check_eq("unexp_valid", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("txn edge=%0d sum=%0d sat=%0d exp_sum=%0d exp_sat=%0d",
                   edge_cnt, out_sum, out_sat, e.sum, e.sat);
          check_eq("sum", 64'(out_sum), 64'(e.sum));
          check_eq("sat", 64'(out_sat), 64'(e.sat));
          check_eq("latency", 64'(edge_cnt), 64'(e.edge_no));
          hold_sum = e.sum;
          hold_sat = e.sat;
        end
      end else begin
        check_eq("hold_sum", 64'(out_sum), 64'(hold_sum));
        check_eq("hold_sat", 64'(out_sat), 64'(hold_sat));
      end
    end
  end

  initial begin
    ones    = {16{8'h01}};
    ffs     = {16{8'hFF}};
    grp_b_w = {8'd2, 120'd0};
    grp_b_f = {8'd3, 120'd0};

    // Reset state
    #1;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_sum",   64'(out_sum),   64'd0);
    check_eq("rst_sat",   64'(out_sat),   64'd0);
    check_eq("rst_busy",  64'(busy),      64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single pair, all ones
    send(ones, ones, 1'b1, 1'b1, 1'b1, 16, 1'b0);
    @(posedge clk); #2;
    check_eq("busy_pipe", 64'(busy), 64'd1);
    idle(4);
    @(posedge clk); #2;
    check_eq("busy_idle", 64'(busy), 64'd0);

    // Single pair, all 0xFF
    send(ffs, ffs, 1'b1, 1'b1, 1'b1, 64'h0FE010, 1'b0);
    idle(3);

    // 17 max pairs saturate
    for (int i = 1; i <= 17; i++)
      send(ffs, ffs, i == 1, i == 17, 1'b1, 64'hFFFFFF, 1'b1);
    idle(3);

    // Back-to-back groups
    send(ones, ones, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    send(ones, ones, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    send(ones, ones, 1'b0, 1'b1, 1'b1, 48, 1'b0);
    send(grp_b_w, grp_b_f, 1'b1, 1'b1, 1'b1, 6, 1'b0);
    idle(3);

    // Restart mid-group discards the partial sum
    send(ones, ones, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    send(ones, ones, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    @(posedge clk); #2;
    check_eq("busy_acc", 64'(busy), 64'd1);
    send(ones, ones, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    send(ones, ones, 1'b0, 1'b1, 1'b1, 32, 1'b0);
    idle(4);

    // Pair without first while idle opens a group
    send(ones, ones, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    send(ffs, ones, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    idle(4);

    // Reset one cycle after a last-tagged pair drops it
    send(ones, ones, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    check_eq("busy_pre_rst", 64'(busy), 64'd1);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    hold_sum = 0;
    hold_sat = 1'b0;
    model_open = 1'b0;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_sum",   64'(out_sum),   64'd0);
    check_eq("arst_sat",   64'(out_sat),   64'd0);
    check_eq("arst_busy",  64'(busy),      64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(6);

    // Random groups with idle gaps
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
      end else begin
        logic [127:0] w, f;
        bit fi, la;
        w  = {$urandom(), $urandom(), $urandom(), $urandom()};
        f  = {$urandom(), $urandom(), $urandom(), $urandom()};
        fi = model_open ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
        la = ($urandom_range(0, 3) == 0) || (i == 59);
        send(w, f, fi, la, 1'b0, 0, 1'b0);
      end
    end
    idle(8);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
